// File: rtl/range_input_sequencer.sv
// Front end of the range-finding datapath: synchronises the pin inputs, detects
// strobe/end rising edges and turns them into a go/finish run protocol.
module range_input_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DATA_BITS   = 8,
  parameter int MAX_SAMPLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sample_pin,
  input  logic                 strobe_pin,
  input  logic                 end_pin,
  output logic                 go,
  output logic                 finish,
  output logic [WIDTH-1:0]     data_out,
  output logic [7:0]           sample_count,
  output logic                 busy,
  output logic                 seq_error
);

  localparam logic [7:0] MAX_COUNT = 8'(MAX_SAMPLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] sample_s1, sample_s2;
  logic                 strobe_s1, strobe_s2, strobe_s3;
  logic                 end_s1, end_s2, end_s3;
  logic                 strobe_rise, end_rise;
  logic                 go_next, finish_next, error_next;
  logic [WIDTH-1:0]     data_next;
  logic [7:0]           count_next;

  // Two-flop synchronisers; the third stage on strobe/end feeds edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_s1 <= '0;
      sample_s2 <= '0;
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      strobe_s3 <= 1'b0;
      end_s1    <= 1'b0;
      end_s2    <= 1'b0;
      end_s3    <= 1'b0;
    end else begin
      sample_s1 <= sample_pin;
      sample_s2 <= sample_s1;
      strobe_s1 <= strobe_pin;
      strobe_s2 <= strobe_s1;
      strobe_s3 <= strobe_s2;
      end_s1    <= end_pin;
      end_s2    <= end_s1;
      end_s3    <= end_s2;
    end
  end

  assign strobe_rise = strobe_s2 & ~strobe_s3;
  assign end_rise    = end_s2 & ~end_s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      go           <= 1'b0;
      finish       <= 1'b0;
      data_out     <= '0;
      sample_count <= '0;
      seq_error    <= 1'b0;
    end else begin
      state        <= state_next;
      go           <= go_next;
      finish       <= finish_next;
      data_out     <= data_next;
      sample_count <= count_next;
      seq_error    <= error_next;
    end
  end

  always_comb begin
    state_next  = state;
    go_next     = 1'b0;
    finish_next = 1'b0;
    data_next   = data_out;
    count_next  = sample_count;
    error_next  = seq_error;
    unique case (state)
      IDLE: begin
        // A strobe takes priority over a simultaneous end press.
        if (strobe_rise) begin
          data_next  = WIDTH'(sample_s2);
          go_next    = 1'b1;
          count_next = 8'd1;
          error_next = 1'b0;
          if (MAX_COUNT == 8'd1) finish_next = 1'b1;
          else                   state_next  = RUN;
        end else if (end_rise) begin
          error_next = 1'b1;
        end
      end
      RUN: begin
        if (strobe_rise) begin
          data_next  = WIDTH'(sample_s2);
          count_next = sample_count + 8'd1;
          if (end_rise || (sample_count + 8'd1 == MAX_COUNT)) begin
            finish_next = 1'b1;
            state_next  = IDLE;
          end
        end else if (end_rise) begin
          finish_next = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_range_input_sequencer.sv
// Directed bench for range_input_sequencer: every change of the visible outputs
// is matched against an expected-event queue, one queue per DUT instance.
module tb_range_input_sequencer;

  logic        clock;
  logic        reset;
  logic [7:0]  sample_a, sample_b;
  logic        strobe_a, strobe_b, end_a, end_b;
  logic        go_a, finish_a, busy_a, err_a, go_b, finish_b, busy_b, err_b;
  logic [15:0] data_a, data_b;
  logic [7:0]  count_a, count_b;

  logic [27:0] exp_q[$];
  logic [27:0] exp3_q[$];
  logic [27:0] prev_a, prev_b, cur_a, cur_b;
  int          checks, errors;

  range_input_sequencer dut_a (
    .clock(clock), .reset(reset), .sample_pin(sample_a), .strobe_pin(strobe_a),
    .end_pin(end_a), .go(go_a), .finish(finish_a), .data_out(data_a),
    .sample_count(count_a), .busy(busy_a), .seq_error(err_a)
  );

  range_input_sequencer #(.MAX_SAMPLES(3)) dut_b (
    .clock(clock), .reset(reset), .sample_pin(sample_b), .strobe_pin(strobe_b),
    .end_pin(end_b), .go(go_b), .finish(finish_b), .data_out(data_b),
    .sample_count(count_b), .busy(busy_b), .seq_error(err_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign cur_a = {go_a, finish_a, busy_a, err_a, data_a, count_a};
  assign cur_b = {go_b, finish_b, busy_b, err_b, data_b, count_b};

  function automatic logic [27:0] mk(input bit g, input bit f, input bit bz, input bit er,
                                     input logic [15:0] d, input logic [7:0] c);
    return {g, f, bz, er, d, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected event plus the settle state one cycle later once go/finish drop.
  task automatic push_exp(input bit b, input logic [27:0] e);
    logic [27:0] settled;
    settled = e;
    settled[27:26] = 2'b00;
    if (b) exp3_q.push_back(e); else exp_q.push_back(e);
    if (e[27] || e[26]) begin
      if (b) exp3_q.push_back(settled); else exp_q.push_back(settled);
    end
  endtask

  // driver tasks
  task automatic press(input bit b, input logic [7:0] val, input bit do_strobe,
                       input bit do_end, input int hold, input logic [27:0] e);
    @(negedge clock);
    if (b) sample_b = val; else sample_a = val;
    repeat (3) @(negedge clock);
    push_exp(b, e);
    if (b) begin strobe_b = do_strobe; end_b = do_end; end
    else   begin strobe_a = do_strobe; end_a = do_end; end
    repeat (hold) @(negedge clock);
    if (b) begin strobe_b = 1'b0; end_b = 1'b0; end
    else   begin strobe_a = 1'b0; end_a = 1'b0; end
    repeat (4) @(negedge clock);
  endtask

  // scoreboard: any change of outputs outside reset must be the next expected event
  always @(negedge clock) begin
    if (reset && cur_a !== prev_a) begin
      if (exp_q.size() == 0) chk("unexpected_event_a", 32'(cur_a), 32'(prev_a));
      else                   chk("event_a", 32'(cur_a), 32'(exp_q.pop_front()));
    end
    if (reset && cur_b !== prev_b) begin
      if (exp3_q.size() == 0) chk("unexpected_event_b", 32'(cur_b), 32'(prev_b));
      else                    chk("event_b", 32'(cur_b), 32'(exp3_q.pop_front()));
    end
    prev_a = cur_a;
    prev_b = cur_b;
  end

  initial begin
    checks = 0; errors = 0;
    prev_a = '0; prev_b = '0;
    reset = 1'b0;
    sample_a = '0; sample_b = '0;
    strobe_a = 1'b0; strobe_b = 1'b0; end_a = 1'b0; end_b = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_a", 32'(cur_a), 32'd0);
    chk("reset_b", 32'(cur_b), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // First run with explicit latency checks on go
    sample_a = 8'h2A;
    repeat (3) @(negedge clock);
    push_exp(1'b0, mk(1, 0, 1, 0, 16'h002A, 8'd1));
    strobe_a = 1'b1;
    @(negedge clock);
    chk("go_after_k", 32'(go_a), 32'd0);
    @(negedge clock);
    chk("go_after_k1", 32'(go_a), 32'd0);
    @(negedge clock);
    chk("go_after_k2", 32'(go_a), 32'd1);
    chk("data_first", 32'(data_a), 32'h002A);
    chk("busy_first", 32'(busy_a), 32'd1);
    chk("count_first", 32'(count_a), 32'd1);
    @(negedge clock);
    chk("go_one_cycle", 32'(go_a), 32'd0);
    repeat (2) @(negedge clock);
    strobe_a = 1'b0;
    repeat (4) @(negedge clock);

    press(1'b0, 8'h05, 1, 0, 4, mk(0, 0, 1, 0, 16'h0005, 8'd2));
    press(1'b0, 8'hF0, 1, 0, 4, mk(0, 0, 1, 0, 16'h00F0, 8'd3));
    press(1'b0, 8'h99, 0, 1, 4, mk(0, 1, 0, 0, 16'h00F0, 8'd3));
    chk("finish_dropped", 32'(finish_a), 32'd0);
    chk("data_held", 32'(data_a), 32'h00F0);

    // End press while idle flags an error; the next go clears it
    press(1'b0, 8'h00, 0, 1, 4, mk(0, 0, 0, 1, 16'h00F0, 8'd3));
    press(1'b0, 8'h11, 1, 0, 4, mk(1, 0, 1, 0, 16'h0011, 8'd1));
    press(1'b0, 8'h7F, 1, 1, 4, mk(0, 1, 0, 0, 16'h007F, 8'd2));
    chk("idle_after_joint", 32'(busy_a), 32'd0);

    // Auto-finish on the small instance
    press(1'b1, 8'h01, 1, 0, 4, mk(1, 0, 1, 0, 16'h0001, 8'd1));
    press(1'b1, 8'h02, 1, 0, 4, mk(0, 0, 1, 0, 16'h0002, 8'd2));
    press(1'b1, 8'h03, 1, 0, 4, mk(0, 1, 0, 0, 16'h0003, 8'd3));
    press(1'b1, 8'h04, 1, 0, 4, mk(1, 0, 1, 0, 16'h0004, 8'd1));

    // Held strobe gives a single go
    press(1'b0, 8'h33, 1, 0, 20, mk(1, 0, 1, 0, 16'h0033, 8'd1));
    chk("queue_a_drained", 32'(exp_q.size()), 32'd0);
    chk("queue_b_drained", 32'(exp3_q.size()), 32'd0);

    // Reset mid-run clears everything at once and emits no finish
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset_a", 32'(cur_a), 32'd0);
    chk("midrun_reset_b", 32'(cur_b), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Strobe and end together from idle: strobe wins, no error
    press(1'b0, 8'h44, 1, 1, 4, mk(1, 0, 1, 0, 16'h0044, 8'd1));
    press(1'b0, 8'h00, 0, 1, 4, mk(0, 1, 0, 0, 16'h0044, 8'd1));
    press(1'b0, 8'h5A, 1, 0, 4, mk(1, 0, 1, 0, 16'h005A, 8'd1));

    repeat (5) @(negedge clock);
    chk("final_queue_a", 32'(exp_q.size()), 32'd0);
    chk("final_queue_b", 32'(exp3_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_input_sequencer.md
Name: range_input_sequencer

Overview:
- Upstream stage of the range-finding datapath; sits between the raw chip pins and the range unit.
- Synchronises asynchronous pin inputs (sample byte, strobe button, end button) and detects their rising edges.
- Turns those edges into a clean one-cycle go / finish protocol with a held, zero-extended sample bus.
- Also tracks sample count and flags protocol misuse.

Parameters:
- WIDTH, 16, width of data_out; must be >= DATA_BITS.
- DATA_BITS, 8, width of sample_pin.
- MAX_SAMPLES, 255, samples per run before an automatic finish; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_pin  input  DATA_BITS  raw sample byte from pins (asynchronous).
- strobe_pin  input  1  raw "take sample" button (asynchronous, level).
- end_pin  input  1  raw "end run" button (asynchronous, level).
- go  output  1  one-cycle pulse coincident with the first sample of a run.
- finish  output  1  one-cycle pulse ending a run.
- data_out  output  WIDTH  current sample, zero-extended; held between strobes.
- sample_count  output  8  samples accepted in the current or last run.
- busy  output  1  high while in RUN.
- seq_error  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops, state, go, finish, data_out, sample_count, busy and seq_error go to 0; state=IDLE.
- Synchroniser and edge detection:
  - strobe_pin, end_pin and each sample_pin bit pass through 2 flops (s1, s2).
  - A third flop s3 on strobe/end drives rising-edge detect: rise = s2 & ~s3.
- Latency: a pin first sampled high at edge k is detected after edge k+1; the go/finish/data_out update registers at edge k+2. Pins must be stable for >=3 cycles on both sides of a strobe edge. Held high levels produce no further events.
- data_out = {zeros, s2 sample byte} captured on every accepted strobe edge; otherwise held. It keeps its value after finish until the next go.
- Repeats of the same value on consecutive cycles are benign downstream (min/max are idempotent).
- FSM states IDLE and RUN:
  - IDLE, strobe rise: capture data, go=1, sample_count=1, seq_error=0, -> RUN. If MAX_SAMPLES=1, also finish=1 in the same cycle and stay IDLE.
  - IDLE, end rise (no strobe): seq_error=1, no finish, stay IDLE.
  - IDLE, strobe and end rise in the same cycle: strobe wins; end is ignored, no error.
  - RUN, strobe rise: capture data, sample_count+1.
  - RUN, end rise: finish=1, -> IDLE.
  - RUN, strobe and end rise together: capture data and count the sample, finish=1 in the same cycle, -> IDLE.
  - RUN, strobe rise making sample_count == MAX_SAMPLES: capture, finish=1, -> IDLE (auto-finish). Further strobes then start a new run.
- go and finish are never high for two consecutive cycles from one edge.
- go and finish are simultaneously high only when MAX_SAMPLES=1.
- busy = (state==RUN).
- sample_count is held after finish; cleared to 1 only at the next go. It never exceeds MAX_SAMPLES.
- seq_error is sticky until the next go or reset.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No finish is emitted.

Test Plan:
- Reset, then sample_pin=0x2A, strobe_pin high at edge k -> go=1 and data_out=0x002A during the cycle after edge k+2 only; busy=1; sample_count=1.
- In RUN, strobes with 0x05, 0xF0, then end_pin rise -> data_out tracks 0x0005, 0x00F0; sample_count=3; finish one cycle; busy=0; data_out holds 0x00F0.
- end_pin rise in IDLE -> seq_error=1, no finish; next strobe with 0x11 -> go=1, seq_error=0.
- In RUN, strobe (0x7F) and end_pin rise on the same edge -> data_out=0x007F, sample_count incremented, finish=1 in the same cycle, -> IDLE.
- MAX_SAMPLES=3: three strobes, no end -> finish on the third capture, sample_count=3; a fourth strobe -> new go, sample_count=1.
- strobe_pin held high 20 cycles -> exactly one go. Reset pulse low mid-run -> go, finish, busy, data_out and sample_count all read 0 immediately.
